// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, default coin values and the
// change-dispenser state encoding.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_5    = 2'd1;
  localparam logic [1:0] COIN_10   = 2'd2;
  localparam logic [1:0] COIN_20   = 2'd3;

  localparam logic [7:0] COIN1_VAL = 8'd5;
  localparam logic [7:0] COIN2_VAL = 8'd10;
  localparam logic [7:0] COIN3_VAL = 8'd20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    DONE   = 2'd3
  } disp_state_e;

endpackage

// File: rtl/coin_picker.sv
// Greedy coin selection: largest denomination not exceeding the remaining
// amount, or COIN_NONE with value 0 when nothing fits.
module coin_picker
  import vm_pkg::*;
#(
  parameter logic [7:0] V1 = COIN1_VAL,
  parameter logic [7:0] V2 = COIN2_VAL,
  parameter logic [7:0] V3 = COIN3_VAL
) (
  input  logic [7:0] rem_i,
  output logic [1:0] code_o,
  output logic [7:0] value_o
);

  // Priority compare from the largest coin down.
  always_comb begin
    code_o  = COIN_NONE;
    value_o = '0;
    if (rem_i >= V3) begin
      code_o  = COIN_20;
      value_o = V3;
    end else if (rem_i >= V2) begin
      code_o  = COIN_10;
      value_o = V2;
    end else if (rem_i >= V1) begin
      code_o  = COIN_5;
      value_o = V1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a surplus balance as coins (largest first) over a
// valid/ready handshake to the coin hopper.
// Optional macro CHANGE_TIMEOUT_EN adds a hopper wait limit and the error port.
module change_dispenser
  import vm_pkg::*;
#(
  parameter logic [7:0] COIN1_PRICE    = COIN1_VAL,
  parameter logic [7:0] COIN2_PRICE    = COIN2_VAL,
  parameter logic [7:0] COIN3_PRICE    = COIN3_VAL,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] change_amt,
  output logic       busy,
  output logic       coin_valid,
  output logic [1:0] coin_sel,
  input  logic       coin_ready,
  output logic       done,
`ifdef CHANGE_TIMEOUT_EN
  output logic       error,
`endif
  output logic [7:0] remainder
);

  disp_state_e state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  remainder_q, remainder_d;
  logic [1:0]  pick_code;
  logic [7:0]  pick_val;
`ifdef CHANGE_TIMEOUT_EN
  logic [7:0]  wait_q, wait_d;
  logic        error_q, error_d;
`endif

  coin_picker #(
    .V1(COIN1_PRICE),
    .V2(COIN2_PRICE),
    .V3(COIN3_PRICE)
  ) u_picker (
    .rem_i  (rem_q),
    .code_o (pick_code),
    .value_o(pick_val)
  );

  // Next-state logic. rem_q is frozen while in ISSUE, so the picker output
  // still gives the value of the coin being issued. remainder is loaded on
  // entry to DONE so it is already valid during the done pulse.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sel_d       = sel_q;
    remainder_d = remainder_q;
`ifdef CHANGE_TIMEOUT_EN
    wait_d      = wait_q;
    error_d     = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = change_amt;
          state_d = SELECT;
`ifdef CHANGE_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end
      SELECT: begin
        sel_d = pick_code;
        if (pick_code != COIN_NONE) begin
          state_d = ISSUE;
`ifdef CHANGE_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else begin
          state_d     = DONE;
          remainder_d = rem_q;
        end
      end
      ISSUE: begin
        if (coin_ready) begin
          rem_d   = rem_q - pick_val;
          state_d = SELECT;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (wait_q == 8'(TIMEOUT_CYCLES - 8'd1)) begin
          state_d     = DONE;
          remainder_d = rem_q;
          error_d     = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      sel_q       <= COIN_NONE;
      remainder_q <= '0;
`ifdef CHANGE_TIMEOUT_EN
      wait_q      <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
      remainder_q <= remainder_d;
`ifdef CHANGE_TIMEOUT_EN
      wait_q      <= wait_d;
      error_q     <= error_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign coin_valid = (state_q == ISSUE);
  assign done       = (state_q == DONE);
  assign coin_sel   = sel_q;
  assign remainder  = remainder_q;
`ifdef CHANGE_TIMEOUT_EN
  assign error      = error_q;
`endif

endmodule
